// File: rtl/cgate_pkg.sv
// Shared mode encoding and helpers for the cgate_pipe complex-gate array.
package cgate_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OAI21 = 2'd0;
    localparam logic [MODE_W-1:0] MODE_AOI21 = 2'd1;
    localparam logic [MODE_W-1:0] MODE_OAI22 = 2'd2;
    localparam logic [MODE_W-1:0] MODE_AOI22 = 2'd3;

    // AOI modes are the odd encodings
    function automatic logic is_aoi(input logic [MODE_W-1:0] m);
        return (m == MODE_AOI21) || (m == MODE_AOI22);
    endfunction

    function automatic logic is_22(input logic [MODE_W-1:0] m);
        return (m == MODE_OAI22) || (m == MODE_AOI22);
    endfunction

endpackage

// File: rtl/cgate_pipe_stage.sv
// Generic valid/ready register slice: loads when empty or draining this cycle.
module cgate_pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready_c,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready_c = !out_valid || out_ready;

    // Data only moves on a real load so the held word stays stable under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/cgate_pipe.sv
// Two-stage pipelined array of per-lane OAI21/AOI21/OAI22/AOI22 gates.
module cgate_pipe
    import cgate_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic [1:0]       y_mode,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam int unsigned S1_W = 2 * W + MODE_W;
    localparam int unsigned S2_W = W + MODE_W;

    logic [W-1:0]      t1_c;
    logic [W-1:0]      t2_c;
    logic              s1_valid;
    logic              s2_ready_c;
    logic [S1_W-1:0]   s1_data;
    logic [MODE_W-1:0] s1_mode;
    logic [W-1:0]      s1_t1;
    logic [W-1:0]      s1_t2;
    logic [W-1:0]      y_c;
    logic [S2_W-1:0]   s2_data;
    logic              accept_c;

    // First-level terms: AND pair for AOI, OR pair for OAI; d joins only in 22 modes
    always_comb begin
        t1_c = a | b;
        t2_c = c;
        if (is_aoi(mode)) begin
            t1_c = a & b;
            if (is_22(mode)) begin
                t2_c = c & d;
            end
        end else if (is_22(mode)) begin
            t2_c = c | d;
        end
    end

    cgate_pipe_stage #(.DW(S1_W)) u_stage1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready_c (in_ready),
        .in_data    ({mode, t1_c, t2_c}),
        .out_valid  (s1_valid),
        .out_ready  (s2_ready_c),
        .out_data   (s1_data)
    );

    assign s1_mode = s1_data[S1_W-1 -: MODE_W];
    assign s1_t1   = s1_data[2*W-1 -: W];
    assign s1_t2   = s1_data[W-1:0];

    // Final inverting combine of the two registered terms
    always_comb begin
        y_c = ~(s1_t1 & s1_t2);
        if (is_aoi(s1_mode)) begin
            y_c = ~(s1_t1 | s1_t2);
        end
    end

    cgate_pipe_stage #(.DW(S2_W)) u_stage2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s1_valid),
        .in_ready_c (s2_ready_c),
        .in_data    ({s1_mode, y_c}),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (s2_data)
    );

    assign y      = s2_data[W-1:0];
    assign y_mode = s2_data[S2_W-1 -: MODE_W];

    assign accept_c = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (accept_c) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cgate_pipe.sv
// Scoreboard bench for cgate_pipe at W=4, CNT_W=3.
module tb_cgate_pipe;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 3;

    typedef struct {
        logic [5:0] exp;
        int         cyc;
    } sb_entry_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic [W-1:0]     d;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     y;
    logic [1:0]       y_mode;
    logic [CNT_W-1:0] beat_cnt;

    int        n_tests;
    int        n_fail;
    int        acc_cnt;
    int        ncyc;
    bit        check_lat;
    bit        rnd_done;
    sb_entry_t sb_q[$];

    cgate_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_mode    (y_mode),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference written straight from the gate equations
    function automatic logic [W-1:0] model(input logic [1:0] m, input logic [W-1:0] ia,
                                           input logic [W-1:0] ib, input logic [W-1:0] ic,
                                           input logic [W-1:0] id);
        case (m)
            2'd0:    return ~((ia | ib) & ic);
            2'd1:    return ~((ia & ib) | ic);
            2'd2:    return ~((ia | ib) & (ic | id));
            default: return ~((ia & ib) | (ic & id));
        endcase
    endfunction

    // Samples at negedge: pushes on accept, pops and compares on output handshake
    task automatic monitor();
        sb_entry_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                sb_q.delete();
                acc_cnt = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out", 32'(1), 32'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("y_and_mode", 32'({y_mode, y}), 32'(e.exp));
                        if (check_lat) check("latency", 32'(ncyc - e.cyc), 32'(2));
                    end
                end
                if (in_valid && in_ready) begin
                    e.exp = {mode, model(mode, a, b, c, d)};
                    e.cyc = ncyc;
                    sb_q.push_back(e);
                    acc_cnt++;
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send(input logic [1:0] m, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ic, input logic [W-1:0] id);
        bit acc;
        in_valid = 1'b1;
        mode = m; a = ia; b = ib; c = ic; d = id;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(sb_q.size()), 32'(0));
    endtask

    task automatic wait_out(input string tag);
        int i;
        for (i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if (!out_valid) check(tag, 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_y", 32'(y), 32'(0));
        check("rst_y_mode", 32'(y_mode), 32'(0));
        check("rst_beat_cnt", 32'(beat_cnt), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        logic [W-1:0] va, vb, vc, vd;
        logic [3:0]   k;
        n_tests = 0; n_fail = 0; acc_cnt = 0; ncyc = 0;
        check_lat = 1'b0; rnd_done = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = '0; a = '0; b = '0; c = '0; d = '0;
        #2;
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        do_reset();

        // Exhaustive: every lane sees all 16 (a,b,c,d) combinations per mode
        check_lat = 1'b1;
        for (int m = 0; m < 4; m++) begin
            for (int j = 0; j < 16; j++) begin
                for (int l = 0; l < int'(W); l++) begin
                    k = 4'((j + l) % 16);
                    va[l] = k[0]; vb[l] = k[1]; vc[l] = k[2]; vd[l] = k[3];
                end
                send(2'(m), va, vb, vc, vd);
            end
        end
        in_valid = 1'b0;
        drain();

        // Directed spot checks against hand-computed values
        send(2'd0, 4'b0011, 4'b0101, 4'b1111, 4'b0000);
        in_valid = 1'b0;
        wait_out("spot0_timeout");
        check("spot0_y", 32'(y), 32'(4'b1000));
        send(2'd3, 4'b0011, 4'b0101, 4'b1100, 4'b1010);
        in_valid = 1'b0;
        wait_out("spot3_timeout");
        check("spot3_y", 32'(y), 32'(4'b0110));
        check("spot3_mode", 32'(y_mode), 32'(3));
        drain();
        check_lat = 1'b0;

        // Backpressure: five beats into a stalled pipe
        do_reset();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(2'(i % 4), 4'(i + 1), 4'(3 * i), 4'(5 + i), 4'(9 - i));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check("bp_in_ready", 32'(in_ready), 32'(0));
                check("bp_beat_cnt", 32'(beat_cnt), 32'(2));
                check("bp_y0", 32'({y_mode, y}), 32'({2'd0, model(2'd0, 4'd1, 4'd0, 4'd5, 4'd9)}));
                repeat (3) @(posedge clk);
                #2;
                check("bp_y_hold", 32'({y_mode, y}), 32'({2'd0, model(2'd0, 4'd1, 4'd0, 4'd5, 4'd9)}));
                check("bp_valid_hold", 32'(out_valid), 32'(1));
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_beat_cnt_final", 32'(beat_cnt), 32'(5));

        // Counter wrap at CNT_W = 3
        do_reset();
        for (int i = 0; i < 9; i++) send(2'(i % 4), 4'(i), 4'(~i), 4'(i * 7), 4'(i + 2));
        in_valid = 1'b0;
        drain();
        check("wrap_beat_cnt", 32'(beat_cnt), 32'(1));

        // Random valid/ready traffic
        do_reset();
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 1) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                         4'($urandom), 4'($urandom));
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rnd_accepts", 32'(acc_cnt), 32'(10000));
        check("rnd_beat_cnt", 32'(beat_cnt), 32'(10000 % 8));

        // Reset while both stages hold data
        do_reset();
        out_ready = 1'b0;
        send(2'd1, 4'hf, 4'hf, 4'h0, 4'h0);
        send(2'd2, 4'h0, 4'h0, 4'h0, 4'h0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_y", 32'(y), 32'(0));
        check("mid_rst_beat_cnt", 32'(beat_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_lat = 1'b1;
        send(2'd3, 4'b1010, 4'b1100, 4'b0110, 4'b0101);
        in_valid = 1'b0;
        drain();
        check("post_rst_y", 32'(y), 32'(model(2'd3, 4'b1010, 4'b1100, 4'b0110, 4'b0101)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
